// File: rtl/motion_macc_pkg.sv
// Shared types and helpers for the key-locked multiply-accumulate engine.
// The saturating add is used only when MACC_SATURATE_EN is defined.
package motion_macc_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_LOAD = 4'b0010,
        S_MAC  = 4'b0100,
        S_DONE = 4'b1000
    } state_t;

    localparam int unsigned IDLE_BIT = 0;
    localparam int unsigned LOAD_BIT = 1;
    localparam int unsigned MAC_BIT  = 2;
    localparam int unsigned DONE_BIT = 3;

    localparam int unsigned CTRL_LSB  = 0;
    localparam int unsigned SHIFT_LSB = 8;
    localparam int unsigned MASK_LSB  = 16;

    // Wide enough to hold the exact sum of two sign-extended accumulators up to 127 bits.
    localparam int unsigned SAT_MAX_W = 128;

    typedef struct packed {
        logic                 sat;
        logic [SAT_MAX_W-1:0] sum;
    } sat_sum_t;

    function automatic sat_sum_t sat_add(input logic signed [SAT_MAX_W-1:0] a,
                                         input logic signed [SAT_MAX_W-1:0] b,
                                         input int unsigned w);
        logic signed [SAT_MAX_W-1:0] lim;
        logic signed [SAT_MAX_W-1:0] s;
        sat_sum_t r;
        lim   = 128'sd1 <<< (w - 1);
        s     = a + b;
        r.sat = 1'b0;
        r.sum = s;
        if (s > lim - 1) begin
            r.sum = lim - 1;
            r.sat = 1'b1;
        end else if (s < -lim) begin
            r.sum = -lim;
            r.sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/motion_macc_key_decode.sv
// Combinational locking-key decode: control polarity byte, shift amount and output mask.
module motion_macc_key_decode
    import motion_macc_pkg::*;
#(
    parameter int              ACC_W     = 64,
    parameter int              KEY_W     = 16 + ACC_W,
    parameter int              SH_W      = 6,
    parameter logic [7:0]      CTRL_ENC  = 8'h3C,
    parameter logic [7:0]      SHIFT_ENC = 8'h05,
    parameter logic [ACC_W-1:0] MASK_ENC = {ACC_W{1'b1}}
) (
    input  logic [KEY_W-1:0] locking_key,
    output logic [7:0]       ctrl_eff,
    output logic [SH_W-1:0]  shift_eff,
    output logic [ACC_W-1:0] mask_eff
);

    logic [7:0] shift_raw;

    assign ctrl_eff  = CTRL_ENC ^ locking_key[CTRL_LSB +: 8];
    assign shift_raw = SHIFT_ENC ^ locking_key[SHIFT_LSB +: 8];
    assign shift_eff = SH_W'(32'(shift_raw) % ACC_W);
    assign mask_eff  = MASK_ENC ^ locking_key[MASK_LSB +: ACC_W];

endmodule

// File: rtl/motion_macc_engine.sv
// Key-locked N-term signed dot product plus bias under the ap_* block handshake.
// Optional MACC_SATURATE_EN: saturating accumulation with a sticky flag ORed into out3[0].
module motion_macc_engine
    import motion_macc_pkg::*;
#(
    parameter int               DATA_W    = 32,
    parameter int               N_TERMS   = 4,
    parameter int               ACC_W     = 64,
    parameter logic [7:0]       CTRL_ENC  = 8'h3C,
    parameter logic [7:0]       SHIFT_ENC = 8'h05,
    parameter logic [ACC_W-1:0] MASK_ENC  = {ACC_W{1'b1}},
    parameter int               KEY_W     = 16 + ACC_W
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    input  logic                      ap_start,
    output logic                      ap_done,
    output logic                      ap_idle,
    output logic                      ap_ready,
    input  logic                      mode,
    input  logic [N_TERMS*DATA_W-1:0] in_x,
    input  logic [N_TERMS*DATA_W-1:0] in_y,
    input  logic [DATA_W-1:0]         in_bias,
    output logic [ACC_W-1:0]          out1,
    output logic                      out1_ap_vld,
    output logic [ACC_W-1:0]          out2,
    output logic                      out2_ap_vld,
    output logic [ACC_W-1:0]          out3,
    output logic                      out3_ap_vld,
    input  logic [KEY_W-1:0]          locking_key
);

    localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
    localparam int SH_W  = (ACC_W > 1) ? $clog2(ACC_W) : 1;

    logic [7:0]       ctrl_eff;
    logic [SH_W-1:0]  shift_eff;
    logic [ACC_W-1:0] mask_eff;

    motion_macc_key_decode #(
        .ACC_W    (ACC_W),
        .KEY_W    (KEY_W),
        .SH_W     (SH_W),
        .CTRL_ENC (CTRL_ENC),
        .SHIFT_ENC(SHIFT_ENC),
        .MASK_ENC (MASK_ENC)
    ) u_key_decode (
        .locking_key(locking_key),
        .ctrl_eff   (ctrl_eff),
        .shift_eff  (shift_eff),
        .mask_eff   (mask_eff)
    );

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             publish;

    // Every control decision compares against a key-derived polarity bit.
    logic start_hit, in_idle, in_load, in_mac, last_term, in_done, carry, idle_req;
    assign start_hit = (ap_start == ctrl_eff[0]);
    assign in_idle   = (state_q[IDLE_BIT] == ctrl_eff[1]);
    assign in_load   = (state_q[LOAD_BIT] == ctrl_eff[2]);
    assign in_mac    = (state_q[MAC_BIT] == ctrl_eff[3]);
    assign last_term = ((cnt_q == CNT_W'(N_TERMS - 1)) == ctrl_eff[4]);
    assign in_done   = (state_q[DONE_BIT] == ctrl_eff[5]);
    assign carry     = (mode == ctrl_eff[6]);
    assign idle_req  = ((!ap_start) == ctrl_eff[7]);

    // A corrupted key can leave the counter past the last lane; fall back to lane 0.
    int                         lane;
    logic [DATA_W-1:0]          x_lane, y_lane;
    logic signed [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]           term, bias_ext, load_val, mac_val;

    assign lane     = (int'(cnt_q) < N_TERMS) ? int'(cnt_q) : 0;
    assign x_lane   = in_x[lane*DATA_W +: DATA_W];
    assign y_lane   = in_y[lane*DATA_W +: DATA_W];
    assign prod     = (2*DATA_W)'($signed(x_lane)) * (2*DATA_W)'($signed(y_lane));
    assign term     = ACC_W'(prod);
    assign bias_ext = ACC_W'($signed(in_bias));

`ifdef MACC_SATURATE_EN
    function automatic logic [ACC_W:0] sat_step(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
        sat_sum_t r;
        r = sat_add(SAT_MAX_W'($signed(a)), SAT_MAX_W'($signed(b)), ACC_W);
        return {r.sat, r.sum[ACC_W-1:0]};
    endfunction

    logic [ACC_W:0] load_res, mac_res;
    logic           sat_q, sat_d;
    assign load_res = sat_step(acc_q, bias_ext);
    assign mac_res  = sat_step(acc_q, term);
    assign load_val = load_res[ACC_W-1:0];
    assign mac_val  = mac_res[ACC_W-1:0];
`else
    assign load_val = acc_q + bias_ext;
    assign mac_val  = acc_q + term;
`endif

    // Every branch assigns a named state, so even a wrong key keeps the register one-hot.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        publish = 1'b0;
`ifdef MACC_SATURATE_EN
        sat_d   = sat_q;
`endif
        if (in_idle) begin
            state_d = start_hit ? S_LOAD : S_IDLE;
        end else if (in_load) begin
            acc_d   = carry ? load_val : bias_ext;
            cnt_d   = '0;
            state_d = S_MAC;
`ifdef MACC_SATURATE_EN
            sat_d   = sat_q | (carry & load_res[ACC_W]);
`endif
        end else if (in_mac) begin
            acc_d = mac_val;
            cnt_d = cnt_q + 1'b1;
`ifdef MACC_SATURATE_EN
            sat_d = sat_q | mac_res[ACC_W];
`endif
            if (last_term) begin
                state_d = S_DONE;
                publish = 1'b1;
            end else begin
                state_d = S_MAC;
            end
        end else begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            out1    <= '0;
            out2    <= '0;
            out3    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            if (publish) begin
                out1 <= acc_d;
                out2 <= acc_d << shift_eff;
`ifdef MACC_SATURATE_EN
                out3 <= (acc_d & mask_eff) | ACC_W'(sat_d);
`else
                out3 <= acc_d & mask_eff;
`endif
            end
        end
    end

`ifdef MACC_SATURATE_EN
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end
`endif

    assign ap_done     = in_done;
    assign ap_ready    = in_done;
    assign out1_ap_vld = in_done;
    assign out2_ap_vld = in_done;
    assign out3_ap_vld = in_done;
    assign ap_idle     = in_idle & idle_req;

endmodule

// File: tb/tb_motion_macc_engine.sv
// Self-checking bench for motion_macc_engine against a dot-product reference model.
// Also exercises the MACC_SATURATE_EN build when that macro is defined.
module tb_motion_macc_engine;

    localparam int DATA_W  = 32;
    localparam int N_TERMS = 4;
    localparam int ACC_W   = 64;
    localparam int KEY_W   = 16 + ACC_W;

    localparam logic [ACC_W-1:0] MASK_ENC  = {ACC_W{1'b1}};
    localparam logic [ACC_W-1:0] MASK_EFF  = 64'hFFFF_FFFF_0000_FFFF;
    localparam int               SHIFT_EFF = 4;
    // Key fields chosen so the decode yields ctrl 8'hFF, shift 4 and mask MASK_EFF.
    localparam logic [KEY_W-1:0] GOOD_KEY  = {MASK_ENC ^ MASK_EFF, 8'h05 ^ 8'h04, 8'hC3};

    logic                      ap_clk = 1'b0;
    logic                      ap_rst;
    logic                      ap_start;
    logic                      ap_done, ap_idle, ap_ready;
    logic                      mode;
    logic [N_TERMS*DATA_W-1:0] in_x, in_y;
    logic [DATA_W-1:0]         in_bias;
    logic [ACC_W-1:0]          out1, out2, out3;
    logic                      out1_ap_vld, out2_ap_vld, out3_ap_vld;
    logic [KEY_W-1:0]          locking_key;

    int checks   = 0;
    int failures = 0;

    logic [ACC_W-1:0] m_acc;
    bit               m_sticky;

    always #5 ap_clk = ~ap_clk;

    motion_macc_engine dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle),
        .ap_ready   (ap_ready),
        .mode       (mode),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_bias    (in_bias),
        .out1       (out1),
        .out1_ap_vld(out1_ap_vld),
        .out2       (out2),
        .out2_ap_vld(out2_ap_vld),
        .out3       (out3),
        .out3_ap_vld(out3_ap_vld),
        .locking_key(locking_key)
    );

    function automatic logic [127:0] pack4(input int a, input int b, input int c, input int d);
        return {a, b, c, d};
    endfunction

    function automatic logic [63:0] model_add(input logic [63:0] a, input logic [63:0] v);
`ifdef MACC_SATURATE_EN
        logic signed [127:0] s;
        s = 128'($signed(a)) + 128'($signed(v));
        if (s > 128'sh7FFF_FFFF_FFFF_FFFF) begin
            m_sticky = 1'b1;
            return 64'h7FFF_FFFF_FFFF_FFFF;
        end
        if (s < -128'sh8000_0000_0000_0000) begin
            m_sticky = 1'b1;
            return 64'h8000_0000_0000_0000;
        end
        return s[63:0];
`else
        return a + v;
`endif
    endfunction

    // Result of one call: optional carried accumulator, plus bias, plus sum of lane products.
    function automatic logic [63:0] model_call(input logic [127:0] x, input logic [127:0] y,
                                               input logic [31:0] b, input logic m);
        logic [63:0] acc;
        logic [31:0] xi, yi;
        acc = m ? model_add(m_acc, 64'(longint'($signed(b)))) : 64'(longint'($signed(b)));
        for (int i = 0; i < N_TERMS; i++) begin
            xi  = x[i*32 +: 32];
            yi  = y[i*32 +: 32];
            acc = model_add(acc, 64'(longint'($signed(xi)) * longint'($signed(yi))));
        end
        m_acc = acc;
        return acc;
    endfunction

    task automatic model_reset();
        m_acc    = '0;
        m_sticky = 1'b0;
    endtask

    task automatic run_call(input logic [127:0] x, input logic [127:0] y, input logic [31:0] b,
                            input logic m, input string tag, output logic [63:0] got1);
        logic [63:0] e1, e2, e3;
        int n;
        e1 = model_call(x, y, b, m);
        e2 = e1 << SHIFT_EFF;
        e3 = (e1 & MASK_EFF) | {63'd0, m_sticky};
        @(negedge ap_clk);
        in_x = x; in_y = y; in_bias = b; mode = m; ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        n = 1;
        while (ap_done !== 1'b1 && n < 40) begin
            @(negedge ap_clk);
            n++;
        end
        checks++;
        if (n != N_TERMS + 2) begin
            failures++;
            $display("FAIL %s latency: got %0d want %0d", tag, n, N_TERMS + 2);
        end
        checks++;
        if ({out1_ap_vld, out2_ap_vld, out3_ap_vld, ap_ready} !== 4'hF) begin
            failures++;
            $display("FAIL %s vld/ready: got %b want 1111", tag,
                     {out1_ap_vld, out2_ap_vld, out3_ap_vld, ap_ready});
        end
        checks++;
        if (out1 !== e1) begin
            failures++;
            $display("FAIL %s out1: got %h want %h", tag, out1, e1);
        end
        checks++;
        if (out2 !== e2) begin
            failures++;
            $display("FAIL %s out2: got %h want %h", tag, out2, e2);
        end
        checks++;
        if (out3 !== e3) begin
            failures++;
            $display("FAIL %s out3: got %h want %h", tag, out3, e3);
        end
        got1 = out1;
        @(negedge ap_clk);
        checks++;
        if (ap_done !== 1'b0 || out1_ap_vld !== 1'b0 || ap_idle !== 1'b1 || out1 !== e1) begin
            failures++;
            $display("FAIL %s pulse/hold: done=%b vld=%b idle=%b out1=%h want 0 0 1 %h", tag,
                     ap_done, out1_ap_vld, ap_idle, out1, e1);
        end
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; ap_start = 1'b0; mode = 1'b0;
        in_x = '0; in_y = '0; in_bias = '0; locking_key = GOOD_KEY;
        model_reset();
        repeat (2) @(negedge ap_clk);
        checks++;
        if ({out1, out2, out3} !== '0) begin
            failures++;
            $display("FAIL reset outputs: got %h %h %h want 0", out1, out2, out3);
        end
        checks++;
        if ({ap_done, ap_ready, out1_ap_vld, out2_ap_vld, out3_ap_vld, ap_idle} !== 6'b000001) begin
            failures++;
            $display("FAIL reset handshake: got %b want 000001",
                     {ap_done, ap_ready, out1_ap_vld, out2_ap_vld, out3_ap_vld, ap_idle});
        end
        ap_rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [63:0] got;
        run_call(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 32'd10, 1'b0, "basic", got);
        checks++;
        if (got !== 64'd80 || out2 !== 64'd1280 || out3 !== 64'd80) begin
            failures++;
            $display("FAIL basic const: got %0d %0d %0d want 80 1280 80", got, out2, out3);
        end
    endtask

    task automatic test_signed();
        logic [63:0] got;
        run_call(pack4(-3, 0, 0, 0), pack4(7, 0, 0, 0), -32'sd1, 1'b0, "signed", got);
        checks++;
        if (got !== 64'hFFFF_FFFF_FFFF_FFEA) begin
            failures++;
            $display("FAIL signed const: got %h want ffffffffffffffea", got);
        end
    endtask

    task automatic test_accumulate();
        logic [63:0] g0, g1, g2;
        run_call(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 32'd10, 1'b0, "acc0", g0);
        run_call(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 32'd10, 1'b1, "acc1", g1);
        run_call(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 32'd10, 1'b0, "acc2", g2);
        checks++;
        if (g0 !== 64'd80 || g1 !== 64'd160 || g2 !== 64'd80) begin
            failures++;
            $display("FAIL accumulate: got %0d %0d %0d want 80 160 80", g0, g1, g2);
        end
    endtask

    task automatic test_random();
        logic [63:0] got;
        logic [127:0] x, y;
        for (int i = 0; i < 8; i++) begin
            x = {$urandom, $urandom, $urandom, $urandom};
            y = {$urandom, $urandom, $urandom, $urandom};
            run_call(x, y, $urandom, 1'($urandom_range(0, 1)), "random", got);
        end
    endtask

    task automatic test_reset_mid_call();
        logic [63:0] got;
        @(negedge ap_clk);
        in_x = pack4(1, 2, 3, 4); in_y = pack4(5, 6, 7, 8); in_bias = 32'd10; mode = 1'b0;
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (2) @(negedge ap_clk);
        #2 ap_rst = 1'b1;
        #1;
        checks++;
        if ({out1, out2, out3} !== '0 || {out1_ap_vld, out2_ap_vld, out3_ap_vld, ap_done} !== 4'h0) begin
            failures++;
            $display("FAIL midreset outputs: got %h %h %h vld/done %b want 0", out1, out2, out3,
                     {out1_ap_vld, out2_ap_vld, out3_ap_vld, ap_done});
        end
        checks++;
        if (ap_idle !== 1'b1) begin
            failures++;
            $display("FAIL midreset idle: got %b want 1", ap_idle);
        end
        model_reset();
        @(negedge ap_clk);
        ap_rst = 1'b0;
        run_call(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 32'd10, 1'b0, "after_reset", got);
        checks++;
        if (got !== 64'd80) begin
            failures++;
            $display("FAIL after_reset const: got %0d want 80", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] e1;
        int t, last, pulses;
        bit bad_space, bad_val;
        e1 = model_call(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 32'd10, 1'b0);
        @(negedge ap_clk);
        in_x = pack4(1, 2, 3, 4); in_y = pack4(5, 6, 7, 8); in_bias = 32'd10; mode = 1'b0;
        ap_start = 1'b1;
        t = 0; last = -1; pulses = 0; bad_space = 0; bad_val = 0;
        while (pulses < 3 && t < 80) begin
            @(negedge ap_clk);
            t++;
            if (ap_done === 1'b1) begin
                pulses++;
                if (last >= 0 && t - last != N_TERMS + 3) bad_space = 1;
                if (out1 !== e1) bad_val = 1;
                last = t;
                if (pulses == 3) ap_start = 1'b0;
            end
        end
        checks++;
        if (pulses != 3) begin
            failures++;
            $display("FAIL b2b pulses: got %0d want 3", pulses);
        end
        checks++;
        if (bad_space) begin
            failures++;
            $display("FAIL b2b spacing: got irregular want %0d", N_TERMS + 3);
        end
        checks++;
        if (bad_val) begin
            failures++;
            $display("FAIL b2b out1: got %h want %h", out1, e1);
        end
        @(negedge ap_clk);
        checks++;
        if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin
            failures++;
            $display("FAIL b2b idle: got idle=%b done=%b want 1 0", ap_idle, ap_done);
        end
    endtask

    task automatic test_wrong_key();
        logic [63:0] got, first_out1;
        int done_cycles;
        bit not_onehot;
        locking_key = GOOD_KEY;
        locking_key[7:0] = 8'h00;
        @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        in_x = pack4(1, 2, 3, 4); in_y = pack4(5, 6, 7, 8); in_bias = 32'd10; mode = 1'b0;
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        done_cycles = 0; not_onehot = 0; first_out1 = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge ap_clk);
            if (!$onehot(dut.state_q)) not_onehot = 1;
            if (ap_done === 1'b1) begin
                if (done_cycles == 0) first_out1 = out1;
                done_cycles++;
            end
        end
        checks++;
        if (not_onehot) begin
            failures++;
            $display("FAIL wrongkey onehot: got non-one-hot state want one-hot");
        end
        checks++;
        if (done_cycles == 1 && first_out1 === 64'd80) begin
            failures++;
            $display("FAIL wrongkey corrupt: got out1=%0d done_cycles=1 want corruption",
                     first_out1);
        end
        locking_key = GOOD_KEY;
        @(negedge ap_clk);
        ap_rst = 1'b1;
        model_reset();
        @(negedge ap_clk);
        ap_rst = 1'b0;
        run_call(pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 32'd10, 1'b0, "recover", got);
    endtask

`ifdef MACC_SATURATE_EN
    task automatic test_saturate();
        logic [63:0] got;
        logic [127:0] v;
        v = {4{32'h7FFF_FFFF}};
        for (int i = 0; i < 3; i++) begin
            run_call(v, v, 32'd0, 1'b1, "saturate", got);
            checks++;
            if (got !== 64'h7FFF_FFFF_FFFF_FFFF) begin
                failures++;
                $display("FAIL saturate const: got %h want 7fffffffffffffff", got);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_accumulate();
        test_random();
        test_reset_mid_call();
        test_back_to_back();
        test_wrong_key();
`ifdef MACC_SATURATE_EN
        test_saturate();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
